// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard.
// In-flight stage entry and forward-select encodings.
package pipe_pkg;

  localparam int MAX_AW   = 8;

  localparam int FSEL_RF  = 0;
  localparam int FSEL_EX  = 1;
  localparam int FSEL_MEM = 2;
  localparam int FSEL_WB  = 3;

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              load;
    logic [MAX_AW-1:0] dst;
  } stage_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard.
// Master drives the issue slot, slave returns stall/bypass.
interface pipe_hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int WB_LAT = 3,
  parameter int FSEL_W = $clog2(WB_LAT + 1)
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic                issue_valid;
  logic                issue_wr;
  logic                issue_load;
  logic [REG_AW-1:0]   issue_dst;
  logic                src1_used;
  logic                src2_used;
  logic [REG_AW-1:0]   src1;
  logic [REG_AW-1:0]   src2;
  logic                flush;
  logic                stall;
  logic [FSEL_W-1:0]   fwd_sel1;
  logic [FSEL_W-1:0]   fwd_sel2;
  logic [NUM_REGS-1:0] pending;
  logic [15:0]         stall_cnt;

  modport master (
    output issue_valid, issue_wr, issue_load,
    output issue_dst, src1_used, src2_used,
    output src1, src2, flush,
    input  stall, fwd_sel1, fwd_sel2,
    input  pending, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_load,
    input  issue_dst, src1_used, src2_used,
    input  src1, src2, flush,
    output stall, fwd_sel1, fwd_sel2,
    output pending, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_scoreboard_hazard_cmp.sv
// One source operand compared against every in-flight stage.
// Reports any live match, the youngest match and load-use.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int WB_LAT    = 3,
  parameter int RF_BYPASS = 1,
  parameter int ZERO_REG  = 1,
  parameter int FSEL_W    = $clog2(WB_LAT + 1)
) (
  input  stage_t [WB_LAT:1] stg,
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  output logic              hit,
  output logic [FSEL_W-1:0] idx,
  output logic              ld
);

  localparam int LAST = (RF_BYPASS != 0) ? WB_LAT - 1 : WB_LAT;

  logic [MAX_AW-1:0] src_x;
  logic              zero_src;
  logic [WB_LAT:1]   m;

  assign src_x    = MAX_AW'(src);
  assign zero_src = (ZERO_REG != 0) && (src == '0);

  // per-stage match, last stage dropped when the RF bypasses itself
  always_comb begin
    m = '0;
    for (int k = 1; k <= WB_LAT; k++) begin
      m[k] = stg[k].v & stg[k].wr & used & ~zero_src &
             (stg[k].dst == src_x) & (k <= LAST);
    end
  end

  // youngest match wins: scan oldest to youngest
  always_comb begin
    idx = '0;
    for (int k = WB_LAT; k >= 1; k--) begin
      if (m[k]) idx = FSEL_W'(k);
    end
  end

  assign hit = |m;
  assign ld  = m[1] & stg[1].load;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard beside decode: tracks in-flight writers,
// decides stall and per-operand bypass selects.
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int WB_LAT      = 3,
  parameter int FWD_EN      = 1,
  parameter int RF_BYPASS   = 1,
  parameter int ZERO_REG    = 1,
  parameter int FLUSH_DEPTH = 0,
  parameter int FSEL_W      = $clog2(WB_LAT + 1)
) (
  input logic clk,
  input logic rst,
  pipe_hazard_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 2 ** REG_AW;

  stage_t [WB_LAT:1]   stg;
  stage_t              issue_e;
  logic                hit1, hit2;
  logic                ld1, ld2;
  logic [FSEL_W-1:0]   idx1, idx2;
  logic                stall;
  logic                accept;
  logic [NUM_REGS-1:0] pend;
  logic [15:0]         cnt;

  hazard_cmp #(
    .REG_AW(REG_AW), .WB_LAT(WB_LAT),
    .RF_BYPASS(RF_BYPASS), .ZERO_REG(ZERO_REG),
    .FSEL_W(FSEL_W)
  ) u_cmp1 (
    .stg(stg), .src(bus.src1), .used(bus.src1_used),
    .hit(hit1), .idx(idx1), .ld(ld1)
  );

  hazard_cmp #(
    .REG_AW(REG_AW), .WB_LAT(WB_LAT),
    .RF_BYPASS(RF_BYPASS), .ZERO_REG(ZERO_REG),
    .FSEL_W(FSEL_W)
  ) u_cmp2 (
    .stg(stg), .src(bus.src2), .used(bus.src2_used),
    .hit(hit2), .idx(idx2), .ld(ld2)
  );

  assign issue_e = '{
    v:    1'b1,
    wr:   bus.issue_wr,
    load: bus.issue_load,
    dst:  MAX_AW'(bus.issue_dst)
  };

  // interlock stalls on any live match, forwarding only on load-use
  always_comb begin
    stall = 1'b0;
    if (bus.issue_valid && !bus.flush) begin
      stall = (FWD_EN != 0) ? (ld1 | ld2) : (hit1 | hit2);
    end
  end

  assign accept = bus.issue_valid & ~stall & ~bus.flush;

  // bypass selects only when forwarding and the issue proceeds
  always_comb begin
    bus.fwd_sel1 = FSEL_W'(FSEL_RF);
    bus.fwd_sel2 = FSEL_W'(FSEL_RF);
    if ((FWD_EN != 0) && !stall) begin
      bus.fwd_sel1 = idx1;
      bus.fwd_sel2 = idx2;
    end
  end

  // one bit per register with a live in-flight writer
  always_comb begin
    pend = '0;
    for (int k = 1; k <= WB_LAT; k++) begin
      if (stg[k].v && stg[k].wr) begin
        pend[stg[k].dst[REG_AW-1:0]] = 1'b1;
      end
    end
    if (ZERO_REG != 0) pend[0] = 1'b0;
  end

  // pipeline shift; flushed young stages never advance
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
      cnt <= '0;
    end else begin
      stg[1] <= accept ? issue_e : '0;
      for (int k = 2; k <= WB_LAT; k++) begin
        if (bus.flush && (k - 1) <= FLUSH_DEPTH) stg[k] <= '0;
        else                                     stg[k] <= stg[k-1];
      end
      if (stall && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  assign bus.stall     = stall;
  assign bus.pending   = pend;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for the hazard scoreboard: forwarding, interlock
// and long-pipe instances driven from scenario tasks.
module tb_pipe_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [3:0] dst;
    logic       u1;
    logic [3:0] s1;
    logic       u2;
    logic [3:0] s2;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic [4:0]  out;
    logic [4:0]  msk;
    logic [15:0] pend;
  } exp_t;

  logic  clk;
  logic  rst;
  stim_t sa, sb, sc;
  exp_t  q[$];
  int    n_chk;
  int    n_fail;
  logic [15:0] cnt_a, cnt_b;

  pipe_hazard_scoreboard_if #(.REG_AW(4), .WB_LAT(3))  ia ();
  pipe_hazard_scoreboard_if #(.REG_AW(4), .WB_LAT(3))  ib ();
  pipe_hazard_scoreboard_if #(.REG_AW(4), .WB_LAT(31)) ic ();

  assign ia.issue_valid = sa.v;
  assign ia.issue_wr    = sa.wr;
  assign ia.issue_load  = sa.ld;
  assign ia.issue_dst   = sa.dst;
  assign ia.src1_used   = sa.u1;
  assign ia.src1        = sa.s1;
  assign ia.src2_used   = sa.u2;
  assign ia.src2        = sa.s2;
  assign ia.flush       = sa.fl;

  assign ib.issue_valid = sb.v;
  assign ib.issue_wr    = sb.wr;
  assign ib.issue_load  = sb.ld;
  assign ib.issue_dst   = sb.dst;
  assign ib.src1_used   = sb.u1;
  assign ib.src1        = sb.s1;
  assign ib.src2_used   = sb.u2;
  assign ib.src2        = sb.s2;
  assign ib.flush       = sb.fl;

  assign ic.issue_valid = sc.v;
  assign ic.issue_wr    = sc.wr;
  assign ic.issue_load  = sc.ld;
  assign ic.issue_dst   = sc.dst;
  assign ic.src1_used   = sc.u1;
  assign ic.src1        = sc.s1;
  assign ic.src2_used   = sc.u2;
  assign ic.src2        = sc.s2;
  assign ic.flush       = sc.fl;

  pipe_hazard_scoreboard #(
    .FWD_EN(1), .RF_BYPASS(1), .WB_LAT(3), .FLUSH_DEPTH(1)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  pipe_hazard_scoreboard #(
    .FWD_EN(0), .RF_BYPASS(1), .WB_LAT(3)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  pipe_hazard_scoreboard #(
    .FWD_EN(0), .RF_BYPASS(0), .WB_LAT(31)
  ) u_c (.clk(clk), .rst(rst), .bus(ic));

  logic [4:0] o_a, o_b;
  assign o_a = {ia.stall, ia.fwd_sel1, ia.fwd_sel2};
  assign o_b = {ib.stall, ib.fwd_sel1, ib.fwd_sel2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(int v, int wr, int ld, int dst,
                               int u1, int s1, int u2, int s2,
                               int fl);
    return {1'(v), 1'(wr), 1'(ld), 4'(dst),
            1'(u1), 4'(s1), 1'(u2), 4'(s2), 1'(fl)};
  endfunction

  task automatic drive_a(input stim_t s, input exp_t e);
    @(negedge clk);
    sa = s;
    q.push_back(e);
  endtask

  task automatic drive_b(input stim_t s, input exp_t e);
    @(negedge clk);
    sb = s;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sa = '0;
      sb = '0;
      sc = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sa  = mk(1, 1, 0, 3, 1, 1, 1, 2, 0);
    sb  = sa;
    sc  = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_chk += 5;
      if (ia.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset stall: got %b want 0", ia.stall);
      end
      if (ia.pending !== 16'h0) begin
        n_fail++;
        $display("FAIL reset pending: got %h want 0", ia.pending);
      end
      if (ia.stall_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset cnt_a: got %h want 0", ia.stall_cnt);
      end
      if (ib.stall_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset cnt_b: got %h want 0", ib.stall_cnt);
      end
      if (ic.stall_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset cnt_c: got %h want 0", ic.stall_cnt);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sa = '0;
    sb = '0;
    #1;
    n_chk += 2;
    if (ia.pending !== 16'h0008) begin
      n_fail++;
      $display("FAIL first issue pend_a: got %h want 0008", ia.pending);
    end
    if (ib.pending !== 16'h0008) begin
      n_fail++;
      $display("FAIL first issue pend_b: got %h want 0008", ib.pending);
    end
    cnt_a = 16'h0;
    cnt_b = 16'h0;
    idle(4);
  endtask

  task automatic test_back_to_back();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = mk(1, 1, 0, 3,  1, 1, 1, 2, 0);
    ex[0] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    st[1] = mk(1, 1, 0, 4,  1, 3, 1, 5, 0);
    ex[1] = '{out: 5'b0_01_00, msk: 5'h1f, pend: 16'h0008};
    st[2] = mk(1, 1, 0, 8,  1, 3, 1, 4, 0);
    ex[2] = '{out: 5'b0_10_01, msk: 5'h1f, pend: 16'h0018};
    st[3] = mk(1, 1, 0, 9,  1, 3, 1, 4, 0);
    ex[3] = '{out: 5'b0_00_10, msk: 5'h1f, pend: 16'h0118};
    st[4] = mk(1, 1, 0, 10, 0, 9, 1, 8, 0);
    ex[4] = '{out: 5'b0_00_10, msk: 5'h1f, pend: 16'h0310};
    for (int i = 0; i < 5; i++) begin
      drive_a(st[i], ex[i]);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (((o_a ^ e.out) & e.msk) !== 5'd0) begin
        n_fail++;
        $display("FAIL b2b[%0d] stall/fwd: got %b want %b",
                 i, o_a, e.out);
      end
      if (ia.pending !== e.pend) begin
        n_fail++;
        $display("FAIL b2b[%0d] pending: got %h want %h",
                 i, ia.pending, e.pend);
      end
      if (ia.stall_cnt !== cnt_a) begin
        n_fail++;
        $display("FAIL b2b[%0d] cnt: got %h want %h",
                 i, ia.stall_cnt, cnt_a);
      end
      if (e.out[4] && cnt_a != 16'hFFFF) cnt_a++;
    end
    idle(4);
  endtask

  task automatic test_load_use();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = mk(1, 1, 1, 6, 0, 0, 0, 0, 0);
    ex[0] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    st[1] = mk(1, 1, 0, 7, 1, 6, 1, 6, 0);
    ex[1] = '{out: 5'b1_00_00, msk: 5'h1f, pend: 16'h0040};
    st[2] = st[1];
    ex[2] = '{out: 5'b0_10_10, msk: 5'h1f, pend: 16'h0040};
    for (int i = 0; i < 3; i++) begin
      drive_a(st[i], ex[i]);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (((o_a ^ e.out) & e.msk) !== 5'd0) begin
        n_fail++;
        $display("FAIL load_use[%0d] stall/fwd: got %b want %b",
                 i, o_a, e.out);
      end
      if (ia.pending !== e.pend) begin
        n_fail++;
        $display("FAIL load_use[%0d] pending: got %h want %h",
                 i, ia.pending, e.pend);
      end
      if (ia.stall_cnt !== cnt_a) begin
        n_fail++;
        $display("FAIL load_use[%0d] cnt: got %h want %h",
                 i, ia.stall_cnt, cnt_a);
      end
      if (e.out[4] && cnt_a != 16'hFFFF) cnt_a++;
    end
    idle(4);
  endtask

  task automatic test_zero_reg();
    stim_t st[2];
    exp_t  ex[2];
    exp_t  e;
    st[0] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    ex[0] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    st[1] = mk(1, 1, 0, 5, 1, 0, 1, 0, 0);
    ex[1] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    for (int i = 0; i < 2; i++) begin
      drive_a(st[i], ex[i]);
      #1;
      e = q.pop_front();
      n_chk += 2;
      if (((o_a ^ e.out) & e.msk) !== 5'd0) begin
        n_fail++;
        $display("FAIL zero[%0d] stall/fwd: got %b want %b",
                 i, o_a, e.out);
      end
      if (ia.pending !== e.pend) begin
        n_fail++;
        $display("FAIL zero[%0d] pending: got %h want %h",
                 i, ia.pending, e.pend);
      end
    end
    idle(4);
  endtask

  task automatic test_flush();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = mk(1, 1, 1, 6, 0, 0, 0, 0, 0);
    ex[0] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    st[1] = mk(1, 1, 0, 7, 1, 6, 1, 6, 1);
    ex[1] = '{out: 5'b0_00_00, msk: 5'h10, pend: 16'h0040};
    st[2] = mk(1, 1, 0, 7, 1, 6, 1, 6, 0);
    ex[2] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    for (int i = 0; i < 3; i++) begin
      drive_a(st[i], ex[i]);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (((o_a ^ e.out) & e.msk) !== 5'd0) begin
        n_fail++;
        $display("FAIL flush[%0d] stall/fwd: got %b want %b",
                 i, o_a, e.out);
      end
      if (ia.pending !== e.pend) begin
        n_fail++;
        $display("FAIL flush[%0d] pending: got %h want %h",
                 i, ia.pending, e.pend);
      end
      if (ia.stall_cnt !== cnt_a) begin
        n_fail++;
        $display("FAIL flush[%0d] cnt: got %h want %h",
                 i, ia.stall_cnt, cnt_a);
      end
      if (e.out[4] && cnt_a != 16'hFFFF) cnt_a++;
    end
    idle(4);
  endtask

  task automatic test_interlock();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = mk(1, 1, 0, 3, 1, 1, 1, 2, 0);
    ex[0] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0000};
    st[1] = mk(1, 1, 0, 4, 1, 3, 0, 0, 0);
    ex[1] = '{out: 5'b1_00_00, msk: 5'h1f, pend: 16'h0008};
    st[2] = st[1];
    ex[2] = '{out: 5'b1_00_00, msk: 5'h1f, pend: 16'h0008};
    st[3] = st[1];
    ex[3] = '{out: 5'b0_00_00, msk: 5'h1f, pend: 16'h0008};
    for (int i = 0; i < 4; i++) begin
      drive_b(st[i], ex[i]);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (((o_b ^ e.out) & e.msk) !== 5'd0) begin
        n_fail++;
        $display("FAIL ilock[%0d] stall/fwd: got %b want %b",
                 i, o_b, e.out);
      end
      if (ib.pending !== e.pend) begin
        n_fail++;
        $display("FAIL ilock[%0d] pending: got %h want %h",
                 i, ib.pending, e.pend);
      end
      if (ib.stall_cnt !== cnt_b) begin
        n_fail++;
        $display("FAIL ilock[%0d] cnt: got %h want %h",
                 i, ib.stall_cnt, cnt_b);
      end
      if (e.out[4] && cnt_b != 16'hFFFF) cnt_b++;
    end
    idle(1);
    #1;
    n_chk++;
    if (ib.stall_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL ilock total cnt: got %h want 0002", ib.stall_cnt);
    end
    idle(3);
  endtask

  task automatic test_saturation();
    logic [15:0] m;
    m = 16'h0;
    @(negedge clk);
    sc = mk(1, 1, 0, 3, 1, 3, 0, 0, 0);
    for (int j = 1; j <= 67700; j++) begin
      @(negedge clk);
      if (((j - 1) % 32) != 0 && m != 16'hFFFF) m++;
      if (j == 67648) begin
        #1;
        n_chk++;
        if (ic.stall_cnt !== m) begin
          n_fail++;
          $display("FAIL sat pre cnt: got %h want %h",
                   ic.stall_cnt, m);
        end
      end
    end
    #1;
    n_chk += 3;
    if (ic.stall_cnt !== m) begin
      n_fail++;
      $display("FAIL sat model cnt: got %h want %h", ic.stall_cnt, m);
    end
    if (ic.stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat cnt: got %h want ffff", ic.stall_cnt);
    end
    if (ic.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sat stall: got %b want 1", ic.stall);
    end
    idle(33);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    sa = mk(1, 1, 1, 6, 0, 0, 0, 0, 0);
    @(negedge clk);
    sa  = mk(1, 1, 0, 7, 1, 6, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk += 4;
    if (ia.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst stall: got %b want 0", ia.stall);
    end
    if (ia.pending !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst pending: got %h want 0", ia.pending);
    end
    if (ia.stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst cnt_a: got %h want 0", ia.stall_cnt);
    end
    if (ib.stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst cnt_b: got %h want 0", ib.stall_cnt);
    end
    idle(2);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cnt_a  = 16'h0;
    cnt_b  = 16'h0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_interlock();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
